// File: rtl/pair_serializer.sv
// pair_serializer: buffers {word1, word0} pairs in a DEPTH-entry FIFO and
// emits them as a single-word valid/ready stream, word 0 first, with out_last
// marking word 1.
// Optional feature macro: PAIR_SERIALIZER_CHECKSUM_EN adds chk_clr/checksum,
// an XOR accumulator over every accepted output word.
module pair_serializer #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         data_in_0,
    input  logic [WIDTH-1:0]         data_in_1,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         data_out,
    output logic                     out_last,
`ifdef PAIR_SERIALIZER_CHECKSUM_EN
    input  logic                     chk_clr,
    output logic [WIDTH-1:0]         checksum,
`endif
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    typedef enum logic {
        WORD0 = 1'b0,
        WORD1 = 1'b1
    } state_t;

    logic [PW:0]          wr_ptr_q, wr_ptr_d;
    logic [PW:0]          rd_ptr_q, rd_ptr_d;
    logic [PW:0]          count;
    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   mem_q [DEPTH];
    logic [2*WIDTH-1:0]   head;
    logic                 push;
    logic                 accept;
    logic                 pop;

    // The extra wrap bit makes the pointer difference the exact occupancy.
    assign count = wr_ptr_q - rd_ptr_q;

    // Flow control, output word mux, pointer and word-select next state.
    always_comb begin
        in_ready  = (count != FULL_CNT);
        out_valid = (count != '0);
        level     = count;
        head      = mem_q[rd_ptr_q[PW-1:0]];
        push      = in_valid && in_ready;
        accept    = out_valid && out_ready;
        pop       = accept && (state_q == WORD1);
        data_out  = '0;
        out_last  = 1'b0;
        if (out_valid) begin
            data_out = (state_q == WORD1) ? head[2*WIDTH-1:WIDTH] : head[WIDTH-1:0];
            out_last = (state_q == WORD1);
        end
        wr_ptr_d = wr_ptr_q + (PW+1)'(push);
        rd_ptr_d = rd_ptr_q + (PW+1)'(pop);
        state_d  = state_q;
        if (accept) begin
            state_d = (state_q == WORD0) ? WORD1 : WORD0;
        end
    end

    // Pointer and word-select registers; reset discards any stored pairs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            state_q  <= WORD0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            state_q  <= state_d;
        end
    end

    // Pair storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[PW-1:0]] <= {data_in_1, data_in_0};
        end
    end

`ifdef PAIR_SERIALIZER_CHECKSUM_EN
    logic [WIDTH-1:0] checksum_q, checksum_d;

    // Clear takes effect before the accumulate of a same-cycle accepted word.
    always_comb begin
        checksum_d = chk_clr ? '0 : checksum_q;
        if (accept) begin
            checksum_d = checksum_d ^ data_out;
        end
    end

    // Checksum accumulator register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

endmodule
